// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide engine.
//   md_op_e    : 3-bit operation codes presented on muldiv_unit.op
//   md_state_e : engine FSM states, also driven out on the debug port
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_unit_mul_step.sv
// One radix-2^MUL_K multiply step: adds the partial product of the low
// MUL_K multiplier bits and the (already shifted) multiplicand into the
// double-width accumulator.
//   acc       in  2*WIDTH  running product
//   a_shifted in  2*WIDTH  multiplicand aligned to the current digit
//   b_lsbs    in  MUL_K    current multiplier digit
//   acc_next  out 2*WIDTH  acc + b_lsbs * a_shifted
module muldiv_unit_mul_step #(
  parameter int WIDTH = 32,
  parameter int MUL_K = 2
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] a_shifted,
  input  logic [MUL_K-1:0]   b_lsbs,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [2*WIDTH-1:0] b_ext;

  assign b_ext    = {{(2*WIDTH-MUL_K){1'b0}}, b_lsbs};
  assign acc_next = acc + (a_shifted * b_ext);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide engine.
// HI/LO only change on op completion (FIX) or MTHI/MTLO, so an abort from a
// pipeline flush can never leave them half-written.
//   clock, reset  single clock, synchronous active-high reset
//   start, op     launch request and operation code (md_op_e)
//   a, b          rs / rt operands
//   abort         cancel the in-flight op
//   busy          iterative op in flight
//   done          one-cycle pulse in the cycle hi/lo show a new value
//   hi, lo        architectural HI / LO
//   state_dbg     current FSM state
//
// Handshake: start is sampled only while busy is low (IDLE); a start seen
// while busy is dropped and the requester must retry. A start with abort in
// the same cycle is also dropped.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_K      = 2,
  parameter int ENABLE_DIV = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output md_state_e        state_dbg
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] MUL_CYCLES = CNT_W'(WIDTH / MUL_K);
  localparam logic [CNT_W-1:0] DIV_CYCLES = CNT_W'(WIDTH);

  // Conditional two's-complement negate; used both to take magnitudes on
  // entry and to restore signs in FIX.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic s);
    return s ? -x : x;
  endfunction

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;     // MUL: product; DIV: {remainder, quotient}
  logic [2*WIDTH-1:0] mcand_q;   // shifted multiplicand
  logic [WIDTH-1:0]   mplier_q;  // MUL: remaining multiplier; DIV: divisor
  logic [WIDTH-1:0]   a_keep_q;  // raw dividend for divide-by-zero
  logic               neg_q, rem_neg_q, div_zero_q, is_div_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic launch_mul, launch_div, mt_write, commit;
  logic signed_op, is_div_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] mul_next, prod_fix;
  logic [WIDTH:0] div_shift, div_diff;
  logic           div_ge;
  logic [WIDTH-1:0] div_rem;

  assign signed_op = (op == MD_MULT) || (op == MD_DIV);
  assign is_div_op = (op == MD_DIV) || (op == MD_DIVU);
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = neg_if(a, a_neg);
  assign b_mag     = neg_if(b, b_neg);

  muldiv_unit_mul_step #(.WIDTH(WIDTH), .MUL_K(MUL_K)) u_mul_step (
    .acc       (acc_q),
    .a_shifted (mcand_q),
    .b_lsbs    (mplier_q[MUL_K-1:0]),
    .acc_next  (mul_next)
  );

  // Restoring divide: shift the next dividend bit into the partial remainder
  // and keep the difference only when it does not borrow.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mplier_q};
  assign div_ge    = ~div_diff[WIDTH];
  assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];

  assign prod_fix  = neg_q ? -acc_q : acc_q;

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    launch_mul = 1'b0;
    launch_div = 1'b0;
    mt_write   = 1'b0;
    commit     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          case (op)
            MD_MULT, MD_MULTU: begin
              state_d    = ST_MUL;
              launch_mul = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
              // Without a divider the op still runs, as a MULTU of zeros.
              if (ENABLE_DIV != 0) begin
                state_d    = ST_DIV;
                launch_div = 1'b1;
              end else begin
                state_d    = ST_MUL;
                launch_mul = 1'b1;
              end
            end
            MD_MTHI, MD_MTLO: mt_write = 1'b1;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        if (abort)                       state_d = ST_IDLE;
        else if (cnt_q == CNT_W'(1))     state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        commit  = ~abort;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      a_keep_q   <= '0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      is_div_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= mt_write | commit;
      if (mt_write) begin
        if (op == MD_MTHI) hi_q <= a;
        else               lo_q <= a;
      end
      if (launch_mul) begin
        acc_q    <= '0;
        mcand_q  <= is_div_op ? '0 : {{WIDTH{1'b0}}, a_mag};
        mplier_q <= is_div_op ? '0 : b_mag;
        neg_q    <= ~is_div_op & (a_neg ^ b_neg);
        is_div_q <= 1'b0;
        cnt_q    <= MUL_CYCLES;
      end
      if (launch_div) begin
        acc_q      <= {{WIDTH{1'b0}}, a_mag};
        mplier_q   <= b_mag;
        neg_q      <= a_neg ^ b_neg;
        rem_neg_q  <= a_neg;
        div_zero_q <= (b == '0);
        a_keep_q   <= a;
        is_div_q   <= 1'b1;
        cnt_q      <= DIV_CYCLES;
      end
      if (state_q == ST_MUL) begin
        acc_q    <= mul_next;
        mcand_q  <= mcand_q << MUL_K;
        mplier_q <= mplier_q >> MUL_K;
        cnt_q    <= cnt_q - CNT_W'(1);
      end
      if (state_q == ST_DIV) begin
        acc_q <= {div_rem, acc_q[WIDTH-2:0], div_ge};
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (commit) begin
        if (is_div_q && div_zero_q) begin
          lo_q <= '1;
          hi_q <= a_keep_q;
        end else if (is_div_q) begin
          lo_q <= neg_if(acc_q[WIDTH-1:0], neg_q);
          hi_q <= neg_if(acc_q[2*WIDTH-1:WIDTH], rem_neg_q);
        end else begin
          {hi_q, lo_q} <= prod_fix;
        end
      end
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W  = 32;
  localparam int NI = 3;
  localparam logic [W-1:0] MIN_V = 32'h8000_0000;

  // ---------------- clock / reset / DUTs ----------------
  logic clock = 1'b0;
  logic reset, start, abort;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy_v [NI];
  logic         done_v [NI];
  logic [W-1:0] hi_v   [NI];
  logic [W-1:0] lo_v   [NI];
  md_state_e    dbg_v  [NI];
  int kval [NI] = '{1, 2, 4};

  int checks = 0;
  int errors = 0;
  logic [W-1:0]   exp_hi, exp_lo;
  logic [2*W-1:0] exp_q[$];

  always #5 clock = ~clock;

  muldiv_unit #(.WIDTH(W), .MUL_K(1)) u_k1 (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b), .abort(abort),
    .busy(busy_v[0]), .done(done_v[0]), .hi(hi_v[0]), .lo(lo_v[0]), .state_dbg(dbg_v[0]));
  muldiv_unit #(.WIDTH(W), .MUL_K(2)) u_k2 (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b), .abort(abort),
    .busy(busy_v[1]), .done(done_v[1]), .hi(hi_v[1]), .lo(lo_v[1]), .state_dbg(dbg_v[1]));
  muldiv_unit #(.WIDTH(W), .MUL_K(4)) u_k4 (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b), .abort(abort),
    .busy(busy_v[2]), .done(done_v[2]), .hi(hi_v[2]), .lo(lo_v[2]), .state_dbg(dbg_v[2]));

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] ref_model(input logic [2:0] o, input logic [W-1:0] x, y,
                                               input logic [W-1:0] cur_hi, cur_lo);
    longint p;
    int sx, sy, q, r;
    logic [W-1:0] qq, rr;
    case (o)
      3'd0: begin p = longint'($signed(x)) * longint'($signed(y)); return p; end
      3'd1: return {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == MIN_V && y == 32'hFFFF_FFFF) return {32'd0, MIN_V};
        sx = $signed(x); sy = $signed(y);
        q = sx / sy; r = sx % sy;
        qq = q; rr = r;
        return {rr, qq};
      end
      3'd3: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        qq = x / y; rr = x % y;
        return {rr, qq};
      end
      3'd4: return {x, cur_lo};
      3'd5: return {cur_hi, x};
      default: return {cur_hi, cur_lo};
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input int k);
    case (o)
      3'd0, 3'd1: return W / k + 1;
      3'd2, 3'd3: return W + 1;
      default:    return 0;
    endcase
  endfunction

  // ---------------- driver / scoreboard ----------------
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, y, input string name);
    int bcnt [NI];
    int dcnt [NI];
    int lat, exp_done;
    exp_q.push_back(ref_model(o, x, y, exp_hi, exp_lo));
    @(negedge clock);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    a = $urandom; b = $urandom;
    for (int i = 0; i < NI; i++) begin bcnt[i] = 0; dcnt[i] = 0; end
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clock);
      for (int i = 0; i < NI; i++) begin
        if (busy_v[i]) bcnt[i]++;
        if (done_v[i]) dcnt[i]++;
      end
    end
    {exp_hi, exp_lo} = exp_q.pop_front();
    exp_done = (o <= 3'd5) ? 1 : 0;
    for (int i = 0; i < NI; i++) begin
      lat = ref_latency(o, kval[i]);
      checks++;
      if (bcnt[i] !== lat) begin
        errors++; $display("FAIL %s k=%0d busy_cycles: got %0d expected %0d", name, kval[i], bcnt[i], lat);
      end
      checks++;
      if (dcnt[i] !== exp_done) begin
        errors++; $display("FAIL %s k=%0d done_pulses: got %0d expected %0d", name, kval[i], dcnt[i], exp_done);
      end
      checks++;
      if (hi_v[i] !== exp_hi) begin
        errors++; $display("FAIL %s k=%0d hi: got %h expected %h", name, kval[i], hi_v[i], exp_hi);
      end
      checks++;
      if (lo_v[i] !== exp_lo) begin
        errors++; $display("FAIL %s k=%0d lo: got %h expected %h", name, kval[i], lo_v[i], exp_lo);
      end
    end
  endtask

  task automatic check_idle_regs(input string name, input logic exp_busy);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (busy_v[i] !== exp_busy || done_v[i] !== 1'b0 || hi_v[i] !== exp_hi || lo_v[i] !== exp_lo) begin
        errors++;
        $display("FAIL %s k=%0d busy/done/hi/lo: got %b/%b/%h/%h expected %b/0/%h/%h",
                 name, kval[i], busy_v[i], done_v[i], hi_v[i], lo_v[i], exp_busy, exp_hi, exp_lo);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    exp_hi = '0; exp_lo = '0;
    check_idle_regs("reset", 1'b0);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (dbg_v[i] !== ST_IDLE) begin
        errors++; $display("FAIL reset k=%0d state: got %0d expected %0d", kval[i], dbg_v[i], ST_IDLE);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(MD_MULT,  32'hFFFF_FFFD, 32'd7,         "mult_neg3x7");
    run_op(MD_MULT,  32'h8765_4321, 32'd1,         "mult_neg_x1");
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,         "div_neg7_2");
    run_op(MD_DIVU,  32'd100,       32'd7,         "divu_100_7");
    run_op(MD_DIVU,  32'd100,       32'd0,         "divu_by0");
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd0,         "div_neg_by0");
    run_op(MD_DIV,   MIN_V,         32'hFFFF_FFFF, "div_min_m1");
    run_op(MD_DIV,   32'd7,         32'hFFFF_FFFE, "div_7_neg2");
  endtask

  task automatic test_mt();
    run_op(MD_MTHI, 32'hCAFE_F00D, 32'd0, "mthi");
    run_op(MD_MTLO, 32'h1234_5678, 32'd0, "mtlo");
  endtask

  task automatic test_unused();
    run_op(3'd6, 32'h1111_1111, 32'h2, "unused6");
    run_op(3'd7, 32'h2222_2222, 32'h3, "unused7");
  endtask

  task automatic test_abort();
    run_op(MD_MTLO, 32'h1234_5678, 32'd0, "abort_setup");
    @(negedge clock);
    op = MD_MULT; a = 32'd5; b = 32'd5; start = 1'b1;
    @(negedge clock);  // busy cycle 1
    start = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      @(negedge clock);
      if (c == 2) begin op = MD_MTHI; a = 32'hDEAD_BEEF; start = 1'b1; end
      if (c == 3) start = 1'b0;
    end
    check_idle_regs("abort_pre", 1'b1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check_idle_regs("abort_post", 1'b0);
    repeat (40) begin
      @(negedge clock);
      for (int i = 0; i < NI; i++) begin
        if (done_v[i] !== 1'b0) begin
          checks++; errors++; $display("FAIL abort_late_done k=%0d: got 1 expected 0", kval[i]);
        end
      end
    end
    check_idle_regs("abort_hold", 1'b0);
  endtask

  task automatic test_abort_fix();
    @(negedge clock);
    op = MD_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (32) @(negedge clock);  // FIX cycle of every instance
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (dbg_v[i] !== ST_FIX || busy_v[i] !== 1'b1) begin
        errors++; $display("FAIL abort_fix_pre k=%0d state/busy: got %0d/%b expected %0d/1", kval[i], dbg_v[i], busy_v[i], ST_FIX);
      end
    end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check_idle_regs("abort_fix", 1'b0);
  endtask

  task automatic test_abort_idle();
    @(negedge clock);
    op = MD_MTLO; a = 32'h0BAD_0BAD; start = 1'b1; abort = 1'b1;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    check_idle_regs("abort_idle", 1'b0);
    @(negedge clock);
    check_idle_regs("abort_idle_next", 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    op = MD_DIV; a = 32'hFFFF_0000; b = 32'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    check_idle_regs("reset_mid", 1'b0);
  endtask

  task automatic test_random();
    logic [2:0] o;
    logic [W-1:0] x, y;
    int sel;
    for (int n = 0; n < 24; n++) begin
      o = 3'($urandom_range(0, 5));
      x = $urandom;
      y = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) y = '0;
      if (sel == 1) begin x = MIN_V; y = 32'hFFFF_FFFF; end
      if (sel == 2) y = 32'($urandom_range(1, 20));
      run_op(o, x, y, "random");
    end
  endtask

  task automatic test_back_to_back();
    run_op(MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "b2b_mult");
    run_op(MD_DIVU, 32'hFFFF_FFFF, 32'h0001_0000, "b2b_divu");
    run_op(MD_MTHI, 32'h0000_00AA, 32'd0,         "b2b_mthi");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; op = '0; a = '0; b = '0;
    exp_hi = '0; exp_lo = '0;
    test_reset();
    test_directed();
    test_mt();
    test_unused();
    test_abort();
    test_abort_fix();
    test_abort_idle();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
